utopia1_tx_sched: RTL and testbench
===================================

# utopia1_tx_sched

Round-robin scheduler sharing one UTOPIA-1 ATM transmit port among `N_PORTS` cell sources (switch output queues). It arbitrates among pending requests and latches the winning cell's NNI header and payload. It then drives the `txreq`/`txack` handshake and the `nni_*` field bus of `utopia1_atm_tx`, and returns a one-cycle completion pulse to the served source. It sits between the switch egress queues and the UTOPIA-1 TX PHY interface.

## Interface
- `N_PORTS`, default 4: number of requesters, 2..8.
- `CNT_W`, default 16: width of the transmitted-cell counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_PORTS: level request per source; held until that source's `done` bit pulses.
- `cell_in` in N_PORTS*424: per-source cell. Slice i is {payload[383:0], HEC[7:0], PT[2:0], CLP, VCI[15:0], VPI[11:0]}, with VPI at the LSBs.
- `port_en` in N_PORTS: static enable mask; a masked source is never granted.
- `done` out N_PORTS: one-hot, one-cycle pulse when the source's cell has been accepted by the TX block.
- `txreq` out 1: request to `utopia1_atm_tx`.
- `txack` in 1: one-cycle acknowledge from `utopia1_atm_tx`.
- `nni_VPI` out 12, `nni_VCI` out 16, `nni_CLP` out 1, `nni_PT` out 3, `nni_HEC` out 8, `nni_Payload` out 384: registered fields of the granted cell.
- `busy` out 1: high in SEND and GAP.
- `cell_cnt` out CNT_W: total cells sent; wraps modulo 2^CNT_W.

## Operation
- **State machine:** IDLE, SEND, GAP. Encoding lives in the package.
- **IDLE:**
  - If `req & port_en` ≠ 0: compute the winner `sel`, register `cell_in[sel]` onto the `nni_*` outputs, set `txreq`←1, and go to SEND.
  - Otherwise stay in IDLE; outputs hold their last values.
- **Round-robin selection:** search starts at `rr_ptr+1` mod N_PORTS and takes the first index with `req & port_en` set. `rr_ptr` is updated to `sel` only on completion.
- **SEND:**
  - `txreq` and all `nni_*` stay stable; `utopia1_atm_tx` reads the header fields live throughout the cell.
  - Changes to `req` or `cell_in` are ignored.
  - On `txack`=1: `txreq`←0, `done[sel]`←1 (one cycle), `rr_ptr`←`sel`, `cell_cnt`←`cell_cnt`+1, then go to GAP.
- **GAP:** exactly one cycle, then go to IDLE. This guarantees `txreq` is low for at least 2 cycles, covering the TX block's ack→done→reset return path.
- **Requester rule:** `req[i]` must be low in the cycle following `done[i]` if the source has no further cell. A `req` still high in IDLE is a new request.
- **Boundary conditions:**
  - `txack` outside SEND is ignored.
  - `port_en[i]` dropping during SEND does not abort the cell in flight.
  - All requests masked: remain in IDLE with `txreq`=0.
  - `cell_cnt` wraps from all-ones to 0.
- **Reset (including mid-cell):** returns to IDLE. `txreq`, `done`, `busy`, `cell_cnt` and all `nni_*` reset to 0. `rr_ptr` resets to N_PORTS-1, so port 0 has first priority. The TX block shares the same `rst_n`, so there is no partial handshake.

## Timing
- **Request latency:**
  - `req` sampled high at edge k (state IDLE) gives `txreq`=1 and valid `nni_*` from edge k.
  - The TX block leaves its reset state at edge k+1.
- **Completion:** `txack` high in cycle c gives `done` and `txreq`=0 from edge c. The GAP cycle follows, and IDLE is re-entered at edge c+1.
- **Earliest next grant:** the next `txreq` rises at edge c+2, when the TX block is back in its reset state.
- **Throughput:** back-to-back cells are separated only by the TX block's own cell time plus this 2-cycle gap.
- **Registration:** all outputs are registered; there is no combinational path from `req`/`txack` to any output.

## Structure
- **Package `atm_pkg`:**
  - Constants `VPI_W`=12, `VCI_W`=16, `PT_W`=3, `HEC_W`=8, `PAYLOAD_W`=384, `CELL_W`=424.
  - Field-offset localparams for unpacking a `cell_in` slice.
  - State enum `sched_state_t`.
- **Sub-module `rr_pick`:** combinational. Takes the masked request vector and `rr_ptr` and returns `sel` plus `any_req`. It is parameterized by N_PORTS and is reusable by future RX-side arbiters.

## Test plan
- **Single source:** reset; `req`=4'b0100 with VPI=12'hABC, VCI=16'h1234, PT=3'b010, CLP=1. Required: `txreq` rises the next edge with those exact fields; on `txack`, `done`=4'b0100 for one cycle, `cell_cnt`=1, `txreq` low for ≥2 cycles.
- **Round-robin fairness:** all four `req` held high through 8 cells. Required: `done` sequence ports 0,1,2,3,0,1,2,3.
- **Mask:** `port_en`=4'b1010 with all `req` high. Required: only ports 1 and 3 are served, alternating; ports 0 and 2 never receive `done`.
- **Stability:** toggle `cell_in[sel]` and `req[sel]` throughout SEND. Required: `nni_*` unchanged until `txack`; the spurious `txack` pulse injected in IDLE is ignored.
- **Reset mid-cell:** assert `rst_n`=0 during SEND. Required: all outputs 0; after release, port 0 wins first despite a prior `rr_ptr` of 2.
- **Counter wrap:** with CNT_W=4, send 17 cells. Required: `cell_cnt`=1.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared ATM cell constants, field layout and scheduler state encoding for the
// UTOPIA-1 transmit path.
package atm_pkg;
  localparam int VPI_W     = 12;
  localparam int VCI_W     = 16;
  localparam int PT_W      = 3;
  localparam int HEC_W     = 8;
  localparam int PAYLOAD_W = 384;
  localparam int CELL_W    = 424;

  // Bit offsets inside one cell_in slice (VPI at the LSBs)
  localparam int VPI_LSB     = 0;
  localparam int VCI_LSB     = VPI_LSB + VPI_W;
  localparam int CLP_BIT     = VCI_LSB + VCI_W;
  localparam int PT_LSB      = CLP_BIT + 1;
  localparam int HEC_LSB     = PT_LSB + PT_W;
  localparam int PAYLOAD_LSB = HEC_LSB + HEC_W;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [HEC_W-1:0]     hec;
    logic [PT_W-1:0]      pt;
    logic                 clp;
    logic [VCI_W-1:0]     vci;
    logic [VPI_W-1:0]     vpi;
  } nni_cell_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } sched_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N_PORTS.
module rr_pick #(
  parameter int N_PORTS = 4,
  parameter int PW      = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_m,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      sel,
  output logic               any_req
);
  int   idx;
  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req_m[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

  assign any_req = |req_m;
endmodule

// File: rtl/utopia1_tx_sched.sv
// Round-robin scheduler sharing one UTOPIA-1 TX port among N_PORTS cell sources;
// latches the winner's cell onto the nni_* bus and runs the txreq/txack handshake.
module utopia1_tx_sched
  import atm_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS*CELL_W-1:0] cell_in,
  input  logic [N_PORTS-1:0]        port_en,
  output logic [N_PORTS-1:0]        done,
  output logic                      txreq,
  input  logic                      txack,
  output logic [VPI_W-1:0]          nni_VPI,
  output logic [VCI_W-1:0]          nni_VCI,
  output logic                      nni_CLP,
  output logic [PT_W-1:0]           nni_PT,
  output logic [HEC_W-1:0]          nni_HEC,
  output logic [PAYLOAD_W-1:0]      nni_Payload,
  output logic                      busy,
  output logic [CNT_W-1:0]          cell_cnt
);
  localparam int PW = $clog2(N_PORTS);

  sched_state_t        state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d, sel_q, sel_d, pick;
  logic                txreq_q, txreq_d, busy_q, busy_d, any_req;
  logic [N_PORTS-1:0]  done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  nni_cell_t           cell_q, cell_d;
  nni_cell_t           cells [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign cells[g] = {cell_in[g*CELL_W + PAYLOAD_LSB +: PAYLOAD_W],
                       cell_in[g*CELL_W + HEC_LSB     +: HEC_W],
                       cell_in[g*CELL_W + PT_LSB      +: PT_W],
                       cell_in[g*CELL_W + CLP_BIT],
                       cell_in[g*CELL_W + VCI_LSB     +: VCI_W],
                       cell_in[g*CELL_W + VPI_LSB     +: VPI_W]};
  end

  rr_pick #(.N_PORTS(N_PORTS), .PW(PW)) u_pick (
    .req_m   (req & port_en),
    .ptr     (rr_q),
    .sel     (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    txreq_d = txreq_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    cell_d  = cell_q;
    unique case (state_q)
      S_IDLE: if (any_req) begin
        sel_d   = pick;
        cell_d  = cells[pick];
        txreq_d = 1'b1;
        state_d = S_SEND;
      end
      // req, cell_in and port_en are deliberately not looked at while sending
      S_SEND: if (txack) begin
        txreq_d       = 1'b0;
        done_d[sel_q] = 1'b1;
        rr_d          = sel_q;
        cnt_d         = cnt_q + CNT_W'(1);
        state_d       = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= PW'(N_PORTS - 1);
      sel_q   <= '0;
      txreq_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      cnt_q   <= '0;
      cell_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      txreq_q <= txreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      cell_q  <= cell_d;
    end
  end

  assign txreq       = txreq_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cell_cnt    = cnt_q;
  assign nni_VPI     = cell_q.vpi;
  assign nni_VCI     = cell_q.vci;
  assign nni_CLP     = cell_q.clp;
  assign nni_PT      = cell_q.pt;
  assign nni_HEC     = cell_q.hec;
  assign nni_Payload = cell_q.payload;
endmodule

// File: tb/tb_utopia1_tx_sched.sv
// Directed bench for utopia1_tx_sched (4 ports, 4-bit counter to exercise wrap).
module tb_utopia1_tx_sched;
  localparam int NP = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req, port_en, done;
  logic [NP*424-1:0] cell_in;
  logic              txreq, txack, nni_CLP, busy;
  logic [11:0]       nni_VPI;
  logic [15:0]       nni_VCI;
  logic [2:0]        nni_PT;
  logic [7:0]        nni_HEC;
  logic [383:0]      nni_Payload;
  logic [CW-1:0]     cell_cnt;

  int checks = 0, failures = 0;
  logic [CW-1:0] exp_cnt = '0;

  utopia1_tx_sched #(.N_PORTS(NP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cell_in(cell_in), .port_en(port_en),
    .done(done), .txreq(txreq), .txack(txack), .nni_VPI(nni_VPI), .nni_VCI(nni_VCI),
    .nni_CLP(nni_CLP), .nni_PT(nni_PT), .nni_HEC(nni_HEC), .nni_Payload(nni_Payload),
    .busy(busy), .cell_cnt(cell_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [423:0] mk_cell(input logic [11:0] vpi, input logic [15:0] vci,
                                           input logic clp, input logic [2:0] pt,
                                           input logic [7:0] hec, input logic [383:0] pl);
    return {pl, hec, pt, clp, vci, vpi};
  endfunction

  function automatic logic [423:0] dflt_cell(input int i);
    return mk_cell(12'(12'h100 + i), 16'(16'h2000 + i), 1'b0, 3'(i), 8'(8'h40 + i),
                   {12{32'(32'hC0DE0000 + i)}});
  endfunction

  task automatic set_cell(input int i, input logic [423:0] c);
    cell_in[i*424 +: 424] = c;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait for a grant of port p, hold it, ack, and check completion and the gap
  task automatic serve(input int p, input int hold);
    int n;
    n = 0;
    while (!txreq && n < 20) begin tick(); n++; end
    chk("grant", 64'(txreq), 64'd1);
    chk("grant_vpi", 64'(nni_VPI), 64'(12'h100 + p));
    repeat (hold) tick();
    chk("hold_txreq", 64'(txreq), 64'd1);
    txack = 1'b1; tick(); txack = 1'b0;
    exp_cnt++;
    chk("done", 64'(done), 64'(1 << p));
    chk("cnt", 64'(cell_cnt), 64'(exp_cnt));
    chk("txreq_low", 64'(txreq), 64'd0);
    tick();
    chk("done_clr", 64'(done), 64'd0);
    chk("gap_txreq", 64'(txreq), 64'd0);
    chk("gap_busy_off", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; port_en = 4'hF; txack = 1'b0;
    for (int i = 0; i < NP; i++) set_cell(i, dflt_cell(i));
    repeat (2) tick();
    chk("rst_txreq", 64'(txreq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(cell_cnt), 64'd0);
    chk("rst_vpi", 64'(nni_VPI), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single source, exact fields and latency
    set_cell(2, mk_cell(12'hABC, 16'h1234, 1'b1, 3'b010, 8'h5A, {12{32'hDEADBEEF}}));
    req = 4'b0100;
    tick();
    chk("s_txreq", 64'(txreq), 64'd1);
    chk("s_vpi", 64'(nni_VPI), 64'hABC);
    chk("s_vci", 64'(nni_VCI), 64'h1234);
    chk("s_pt", 64'(nni_PT), 64'd2);
    chk("s_clp", 64'(nni_CLP), 64'd1);
    chk("s_pl", nni_Payload[63:0], 64'hDEADBEEF_DEADBEEF);
    chk("s_busy", 64'(busy), 64'd1);
    repeat (2) tick();
    txack = 1'b1; tick(); txack = 1'b0; req = '0;
    exp_cnt++;
    chk("s_done", 64'(done), 64'b0100);
    chk("s_cnt", 64'(cell_cnt), 64'd1);
    chk("s_txreq0", 64'(txreq), 64'd0);
    tick();
    chk("s_gap1", 64'(txreq), 64'd0);
    chk("s_done_clr", 64'(done), 64'd0);
    tick();
    chk("s_gap2", 64'(txreq), 64'd0);
    set_cell(2, dflt_cell(2));

    // Reset mid-cell: with rr_ptr=2, port 3 wins; after reset port 0 must win
    req = 4'hF;
    tick();
    chk("mc_pre_vpi", 64'(nni_VPI), 64'h103);
    rst_n = 1'b0; #1;
    chk("mc_txreq", 64'(txreq), 64'd0);
    chk("mc_busy", 64'(busy), 64'd0);
    chk("mc_cnt", 64'(cell_cnt), 64'd0);
    chk("mc_vpi", 64'(nni_VPI), 64'd0);
    chk("mc_pl", nni_Payload[63:0], 64'd0);
    tick();
    rst_n = 1'b1; exp_cnt = '0;
    tick();
    chk("mc_port0", 64'(nni_VPI), 64'h100);

    // Fairness: all requests held, 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) serve(k % 4, 1);

    // Mask 1010: only 1 and 3, alternating
    port_en = 4'b1010;
    for (int k = 0; k < 4; k++) serve((k % 2) ? 3 : 1, 0);

    // Stability: toggle cell/req/port_en of the granted source during SEND
    port_en = 4'hF; req = 4'b0001;
    tick();
    chk("st_grant", 64'(txreq), 64'd1);
    for (int k = 0; k < 4; k++) begin
      set_cell(0, ~dflt_cell(k));
      req[0] = ~req[0];
      if (k == 2) port_en = 4'b1110;
      tick();
      chk("st_vpi", 64'(nni_VPI), 64'h100);
      chk("st_pl", nni_Payload[63:0], 64'hC0DE0000_C0DE0000);
      chk("st_txreq", 64'(txreq), 64'd1);
    end
    set_cell(0, dflt_cell(0)); port_en = 4'hF; req = 4'b0001;
    txack = 1'b1; tick(); txack = 1'b0; req = '0;
    exp_cnt++;
    chk("st_done", 64'(done), 64'b0001);
    chk("st_cnt", 64'(cell_cnt), 64'(exp_cnt));
    tick();
    // Spurious txack in IDLE
    txack = 1'b1; tick(); txack = 1'b0;
    chk("sp_txreq", 64'(txreq), 64'd0);
    chk("sp_done", 64'(done), 64'd0);
    chk("sp_cnt", 64'(cell_cnt), 64'd13);
    chk("sp_busy", 64'(busy), 64'd0);

    // All requests masked
    port_en = 4'b0000; req = 4'hF;
    repeat (3) tick();
    chk("mask_txreq", 64'(txreq), 64'd0);
    chk("mask_busy", 64'(busy), 64'd0);

    // Counter wrap: 17 cells on a 4-bit counter
    rst_n = 1'b0; port_en = 4'hF;
    tick();
    rst_n = 1'b1; exp_cnt = '0;
    for (int k = 0; k < 17; k++) serve(k % 4, 0);
    chk("wrap_cnt", 64'(cell_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
